uart_autobaud: RTL and testbench
================================

Name: uart_autobaud

Overview:
- Automatic baud-rate detector on the UART receive pin, upstream of the UART control register block.
- Measures a host-sent calibration character 0x55 ('U') on uart_rx_i and produces a 16-bit clocks-per-bit divisor.
- The divisor is in the same units as the UART baud_div register.
- Firmware or a boot FSM reads baud_div_o / valid_o and writes it into the UART baud_div field.

Parameters:
- CNT_W, 20, width of the total-duration counter. Must satisfy 2^CNT_W > 8*65535.
- MIN_DIV, 4, smallest accepted divisor. Smaller results flag an error.
- IDLE_CYC, 64, clocks the line must be continuously high before the first falling edge is accepted.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  synchronous reset, active low
- start_i  in  1  one-cycle request to start a measurement
- uart_rx_i  in  1  asynchronous serial line, idle high
- busy_o  out  1  measurement in progress
- valid_o  out  1  one-cycle pulse: new baud_div_o available
- locked_o  out  1  level: last measurement succeeded
- err_o  out  1  level: last measurement failed
- baud_div_o  out  16  measured clocks per bit

Behaviour:
- Interface: one clock (clk_i); reset rst_ni is synchronous and active-low.
- Reset (rst_ni=0 at a clk_i edge) behaviour:
  - FSM goes to IDLE; reset overrides any measurement in progress.
  - All outputs go to 0. baud_div_o=0.
  - Sync flops go to 1.
- Input conditioning: uart_rx_i passes through a 2-flop synchronizer plus a previous-value register.
  - fall = prev & ~sync.
  - Pin-to-fall latency is 3 cycles. This latency is constant, so it cancels out of the measurement.
- Frame model for 0x55, LSB first: S0 1 0 1 0 1 0 1 0, then stop 1.
  - There are 5 falling edges, 2 bit-times apart.
  - First to fifth falling edge spans exactly 8 bit-times.
- FSM states: IDLE, WAIT_IDLE, WAIT_FALL, MEASURE, DONE, ERROR.
  - IDLE: busy_o=0. start_i -> WAIT_IDLE, clear idle counter, clear err_o and locked_o. baud_div_o holds its old value.
  - WAIT_IDLE: idle counter increments while sync=1 and resets to 0 on sync=0. When it reaches IDLE_CYC -> WAIT_FALL.
  - WAIT_FALL: on fall -> MEASURE.
    - total=1, interval=1, edge_cnt=1.
  - MEASURE: total and interval increment every cycle. On fall:
    - edge_cnt++.
    - First interval (edge 2): store t0=interval.
    - Edges 3..5: require |interval - t0| <= (t0>>2). Otherwise -> ERROR.
    - Interval resets to 1 on each fall.
    - On the 5th fall -> DONE.
  - Timeout: total reaching all-ones in MEASURE -> ERROR. WAIT_IDLE and WAIT_FALL have no timeout; firmware aborts by reset.
  - DONE (one cycle) -> IDLE.
    - div = (total_at_5th_fall - 1 + 4) >> 3, computed at CNT_W+1 bits. total counts fall-to-fall cycles.
    - If div < MIN_DIV or div > 65535 -> ERROR instead.
    - Otherwise baud_div_o=div[15:0], valid_o=1 for one cycle, locked_o=1.
    - valid_o is asserted in the cycle after the 5th fall is detected.
  - ERROR (one cycle) -> IDLE. err_o=1 and stays set until the next accepted start_i. baud_div_o is unchanged and valid_o is not pulsed.
- busy_o=1 in WAIT_IDLE, WAIT_FALL and MEASURE.
- start_i while busy_o=1, DONE or ERROR is ignored.
- locked_o and err_o are never both 1.
- A glitch-length fall is treated as a real edge. The jitter check is the only filter.

Decomposition:
- In tcore_param, add:
  - autobaud_state_e enum covering the six states.
  - AB_EDGES=5 and AB_BITS_LOG2=3 constants.
- Sub-module rx_edge_sync:
  - Contents: 2-flop synchronizer, prev register, fall output, sync level output.
  - Reset value 1 on all flops. Reusable by the UART receiver.

Test Plan:
- Bit period 434 clk (115200 @ 50 MHz), 0x55 sent after 100 idle cycles -> valid_o single pulse, baud_div_o=434, locked_o=1, err_o=0, busy_o low after DONE.
- Bit period 27 clk -> baud_div_o=27. Next run at bit period 100 -> baud_div_o=100 and valid_o pulses again.
- Bit period 434, third low-high pair stretched so interval=1200 (> 868+217) -> err_o=1, no valid_o, baud_div_o keeps its previous value 434.
- Bit period 3 -> div=3 < MIN_DIV -> err_o=1. Separately, with CNT_W=12, line held low after the first fall -> err_o=1 after 4095 cycles.
- Line low at start_i, toggling mid-frame at period 50, then idle 64+ cycles, then a clean frame at period 50 -> no measurement until the idle guard is met, then baud_div_o=50.
- rst_ni=0 for one cycle mid-MEASURE -> next cycle all outputs 0 and FSM in IDLE. start_i pulsed during busy_o=1 -> no restart; a period-40 frame completes with baud_div_o=40.

Source files
------------

// File: rtl/tcore_param.sv
// Shared types and constants for the tcore serial blocks, including
// the UART auto-baud detector.
package tcore_param;

  typedef enum logic [2:0] {
    AB_IDLE,
    AB_WAIT_IDLE,
    AB_WAIT_FALL,
    AB_MEASURE,
    AB_DONE,
    AB_ERROR
  } autobaud_state_e;

  // A 0x55 character has five falling edges, and they span 2^3 bit-times.
  localparam int AB_EDGES     = 5;
  localparam int AB_BITS_LOG2 = 3;

endpackage

// File: rtl/rx_edge_sync.sv
// Brings an asynchronous serial line into clk_i. Provides the synchronized
// level and a one-cycle falling-edge strobe. All flops reset to idle-high.
module rx_edge_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic rx_i,
  output logic sync_o,
  output logic fall_o
);

  logic [1:0] sync_q;
  logic       prev_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], rx_i};
      prev_q <= sync_q[1];
    end
  end

  assign sync_o = sync_q[1];
  assign fall_o = prev_q & ~sync_q[1];

endmodule

// File: rtl/uart_autobaud.sv
// Measures a 0x55 calibration character on the UART rx pin and returns the
// clocks-per-bit divisor in the same units as the UART baud_div register.
//
// state        | meaning
// AB_IDLE      | waiting for start_i; result registers hold their values
// AB_WAIT_IDLE | line must stay high for IDLE_CYC consecutive clocks
// AB_WAIT_FALL | idle guard met, waiting for the start-bit falling edge
// AB_MEASURE   | timing falling edges 2..5 and checking interval jitter
// AB_DONE      | one cycle: divisor latched, valid_o pulses
// AB_ERROR     | one cycle: jitter, timeout or range failure, err_o set
module uart_autobaud
  import tcore_param::*;
#(
  parameter int CNT_W    = 20,
  parameter int MIN_DIV  = 4,
  parameter int IDLE_CYC = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        uart_rx_i,
  output logic        busy_o,
  output logic        valid_o,
  output logic        locked_o,
  output logic        err_o,
  output logic [15:0] baud_div_o
);

  localparam int IDLE_W = $clog2(IDLE_CYC + 1);

  autobaud_state_e state_q, state_d;

  logic              rx_sync, rx_fall;
  logic [IDLE_W-1:0] idle_q;
  logic [CNT_W-1:0]  total_q, interval_q, t0_q, diff;
  logic [2:0]        edge_q;
  logic [15:0]       baud_q;
  logic              locked_q, err_q;
  logic [CNT_W:0]    div_ext;
  logic              jit_ok, div_ok, last_edge;

  rx_edge_sync u_rx_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .rx_i   (uart_rx_i),
    .sync_o (rx_sync),
    .fall_o (rx_fall)
  );

  // The first interval sets the reference; later ones may deviate by t0/4.
  assign diff      = (interval_q >= t0_q) ? (interval_q - t0_q) : (t0_q - interval_q);
  assign jit_ok    = (edge_q == 3'd1) || (diff <= (t0_q >> 2));
  assign last_edge = (edge_q == 3'(AB_EDGES - 1));
  // total already counts fall-to-fall cycles, so (total - 1 + 4) reduces to total + 3.
  assign div_ext   = ({1'b0, total_q} + (CNT_W + 1)'(3)) >> AB_BITS_LOG2;
  assign div_ok    = (32'(div_ext) >= 32'(MIN_DIV)) && (32'(div_ext) <= 32'd65535);

  always_comb begin
    state_d = state_q;
    busy_o  = 1'b0;
    valid_o = 1'b0;
    case (state_q)
      AB_IDLE: begin
        if (start_i) state_d = AB_WAIT_IDLE;
      end
      AB_WAIT_IDLE: begin
        busy_o = 1'b1;
        if (rx_sync && (idle_q == IDLE_W'(IDLE_CYC - 1))) state_d = AB_WAIT_FALL;
      end
      AB_WAIT_FALL: begin
        busy_o = 1'b1;
        if (rx_fall) state_d = AB_MEASURE;
      end
      AB_MEASURE: begin
        busy_o = 1'b1;
        if (&total_q) begin
          state_d = AB_ERROR;
        end else if (rx_fall) begin
          if (!jit_ok)        state_d = AB_ERROR;
          else if (last_edge) state_d = div_ok ? AB_DONE : AB_ERROR;
        end
      end
      AB_DONE: begin
        valid_o = 1'b1;
        state_d = AB_IDLE;
      end
      AB_ERROR: state_d = AB_IDLE;
      default:  state_d = AB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= AB_IDLE;
      idle_q     <= '0;
      total_q    <= '0;
      interval_q <= '0;
      t0_q       <= '0;
      edge_q     <= '0;
      baud_q     <= '0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        AB_IDLE: begin
          if (start_i) begin
            idle_q   <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
          end
        end
        AB_WAIT_IDLE: idle_q <= rx_sync ? idle_q + 1'b1 : '0;
        AB_WAIT_FALL: begin
          if (rx_fall) begin
            total_q    <= 1;
            interval_q <= 1;
            edge_q     <= 3'd1;
          end
        end
        AB_MEASURE: begin
          total_q    <= total_q + 1'b1;
          interval_q <= rx_fall ? CNT_W'(1) : interval_q + 1'b1;
          if (rx_fall) begin
            edge_q <= edge_q + 3'd1;
            if (edge_q == 3'd1) t0_q <= interval_q;
          end
          if (state_d == AB_DONE) begin
            baud_q   <= 16'(div_ext);
            locked_q <= 1'b1;
          end
          if (state_d == AB_ERROR) begin
            err_q    <= 1'b1;
            locked_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign locked_o   = locked_q;
  assign err_o      = err_q;
  assign baud_div_o = baud_q;

endmodule

// File: tb/tb_uart_autobaud.sv
// Directed bench for uart_autobaud: frames built from per-bit durations, an
// arithmetic model of the expected divisor, and a per-cycle output compare.
module tb_uart_autobaud;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic        rx = 1'b1;
  logic        busy_o, valid_o, locked_o, err_o;
  logic [15:0] baud_div_o;

  logic        start_s = 1'b0;
  logic        rx_s = 1'b1;
  logic        busy_s, valid_s, locked_s, err_s;
  logic [15:0] baud_div_s;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;
  int exp_valid_cyc = -1;
  int exp_rst_cyc = -1;
  int exp_div = 0;
  int model_div = 0;

  uart_autobaud #(.CNT_W(20), .MIN_DIV(4), .IDLE_CYC(64)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .uart_rx_i(rx),
    .busy_o(busy_o), .valid_o(valid_o), .locked_o(locked_o), .err_o(err_o),
    .baud_div_o(baud_div_o)
  );

  uart_autobaud #(.CNT_W(12), .MIN_DIV(4), .IDLE_CYC(64)) dut_small (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_s), .uart_rx_i(rx_s),
    .busy_o(busy_s), .valid_o(valid_s), .locked_o(locked_s), .err_o(err_s),
    .baud_div_o(baud_div_s)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Interval k is the low+high pair starting at falling edge k; the divisor
  // is the first-to-fifth fall span over eight bit-times, rounded.
  function automatic void model_frame(input int dur[10], input int cnt_w,
                                      output bit ok, output int div, output int span);
    int t0, iv, cum, dev;
    ok  = 1'b1;
    t0  = dur[0] + dur[1];
    cum = 0;
    for (int k = 0; k < 4; k++) begin
      iv  = dur[2*k] + dur[2*k+1];
      cum = cum + iv;
      if (cum >= (1 << cnt_w) - 1) ok = 1'b0;
      dev = (iv > t0) ? iv - t0 : t0 - iv;
      if (k > 0 && dev > t0 / 4) ok = 1'b0;
    end
    span = cum;
    div  = (cum - 1 + 4) >> 3;
    if (div < 4 || div > 65535) ok = 1'b0;
  endfunction

  // The 5th pin fall reaches the FSM three clocks later, so valid_o shows up
  // at the negedge (span + 3) cycles after the start bit is driven.
  task automatic send_frame(input int dur[10]);
    bit ok;
    int div, span;
    model_frame(dur, 20, ok, div, span);
    if (ok) begin
      exp_div       = div;
      exp_valid_cyc = cyc + span + 3;
    end else begin
      exp_valid_cyc = -1;
    end
    for (int i = 0; i < 10; i++) begin
      rx = (i % 2 == 1) || (i == 9);
      repeat (dur[i]) @(negedge clk_i);
    end
  endtask

  task automatic frame_p(input int p);
    int d[10];
    foreach (d[i]) d[i] = p;
    send_frame(d);
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic check_result(input string tag, input int div, input bit lk, input bit er);
    check({tag, "_baud_div"}, baud_div_o, div);
    check({tag, "_locked"}, locked_o, lk);
    check({tag, "_err"}, err_o, er);
    check({tag, "_busy"}, busy_o, 0);
  endtask

  initial begin
    forever begin
      @(negedge clk_i);
      if (chk_en) begin
        if (cyc == exp_rst_cyc)   model_div = 0;
        if (cyc == exp_valid_cyc) model_div = exp_div;
        check("cyc_valid_o", valid_o, cyc == exp_valid_cyc);
        check("cyc_baud_div_o", baud_div_o, model_div);
        check("cyc_lock_err_excl", locked_o & err_o, 0);
      end
    end
  end

  initial begin
    int d[10];
    int n;

    wait_cyc(3);
    check("rst_busy", busy_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_locked", locked_o, 0);
    check("rst_err", err_o, 0);
    check("rst_baud_div", baud_div_o, 0);
    rst_ni = 1'b1;
    chk_en = 1'b1;

    // 115200 baud at 50 MHz
    pulse_start();
    check("t1_busy_after_start", busy_o, 1);
    wait_cyc(100);
    frame_p(434);
    wait_cyc(5);
    check_result("t1", 434, 1, 0);

    // third low-high pair stretched to 1200 clocks
    pulse_start();
    check("t2_locked_cleared", locked_o, 0);
    wait_cyc(100);
    foreach (d[i]) d[i] = 434;
    d[5] = 766;
    send_frame(d);
    wait_cyc(5);
    check_result("t2", 434, 0, 1);

    pulse_start();
    check("t3_err_cleared", err_o, 0);
    wait_cyc(100);
    frame_p(27);
    wait_cyc(5);
    check_result("t3", 27, 1, 0);

    pulse_start();
    wait_cyc(100);
    frame_p(100);
    wait_cyc(5);
    check_result("t4", 100, 1, 0);

    // divisor 3 is below MIN_DIV
    pulse_start();
    wait_cyc(100);
    frame_p(3);
    wait_cyc(5);
    check_result("t5", 100, 0, 1);

    // line busy at start: no measurement until the idle guard is satisfied
    rx = 1'b0;
    wait_cyc(10);
    pulse_start();
    wait_cyc(20);
    check("t6_busy_guard", busy_o, 1);
    for (int k = 0; k < 3; k++) begin
      rx = 1'b1;
      wait_cyc(50);
      rx = 1'b0;
      wait_cyc(50);
    end
    rx = 1'b1;
    wait_cyc(100);
    frame_p(50);
    wait_cyc(5);
    check_result("t6", 50, 1, 0);

    // reset in the middle of a measurement
    pulse_start();
    wait_cyc(100);
    exp_valid_cyc = -1;
    rx = 1'b0;
    wait_cyc(434);
    rx = 1'b1;
    wait_cyc(434);
    rx = 1'b0;
    wait_cyc(200);
    check("t7_busy_measure", busy_o, 1);
    rst_ni = 1'b0;
    exp_rst_cyc = cyc + 1;
    @(negedge clk_i);
    rst_ni = 1'b1;
    rx = 1'b1;
    check("t7_busy", busy_o, 0);
    check("t7_valid", valid_o, 0);
    check("t7_locked", locked_o, 0);
    check("t7_err", err_o, 0);
    check("t7_baud_div", baud_div_o, 0);

    // start_i pulses while busy must not restart the measurement
    wait_cyc(10);
    pulse_start();
    wait_cyc(20);
    pulse_start();
    wait_cyc(80);
    fork
      frame_p(40);
      begin
        wait_cyc(100);
        check("t8_busy_mid_frame", busy_o, 1);
        pulse_start();
      end
    join
    wait_cyc(5);
    check_result("t8", 40, 1, 0);

    // 12-bit total counter: line stuck low after the first fall times out
    start_s = 1'b1;
    @(negedge clk_i);
    start_s = 1'b0;
    wait_cyc(100);
    rx_s = 1'b0;
    n = cyc;
    wait_cyc(4090);
    check("t9_err_before_timeout", err_s, 0);
    check("t9_busy_before_timeout", busy_s, 1);
    wait_cyc(10);
    check("t9_err_after_timeout", err_s, 1);
    check("t9_busy_after_timeout", busy_s, 0);
    check("t9_locked", locked_s, 0);
    check("t9_valid", valid_s, 0);
    check("t9_baud_div", baud_div_s, 0);
    check("t9_elapsed", cyc - n, 4100);
    rx_s = 1'b1;
    wait_cyc(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog expired");
  end

endmodule
